// File: rtl/memory_responder.sv
// memory_responder: core memory-bus responder with word RAM, LED/timer/UART-FIFO I/O page and unmapped space
module memory_responder #(
  parameter int          RAM_ADDR_WIDTH  = 12,
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter logic [15:0] IO_BASE         = 16'h8000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_read_addr,
  output logic [15:0] o_read_data,
  input  logic [15:0] i_write_addr,
  input  logic [15:0] i_write_data,
  input  logic        i_write_strobe,
  output logic [7:0]  o_led,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid
);
  localparam int          D         = FIFO_DEPTH_LOG2;
  localparam int          RAM_N     = 1 << RAM_ADDR_WIDTH;
  localparam logic [16:0] RAM_WORDS = 17'(RAM_N);
  localparam logic [D:0]  FULL_XOR  = {1'b1, {D{1'b0}}};
  logic [15:0] ram [RAM_N];
  logic [7:0]  tx_mem [2**D];
  logic [7:0]  rx_mem [2**D];
  logic [D:0]  tx_wp, tx_rp, rx_wp, rx_rp;
  logic [31:0] timer;
  logic [15:0] timer_shadow, ram_q, rd_next;
  logic [2:0]  rd_off, wr_off;
  logic        rd_ram, wr_ram, rd_io, wr_io;
  logic        tx_full, tx_empty, rx_full, rx_empty, rx_overflow;
  logic        tx_push, tx_pop, rx_push, rx_pop, ovf_set, ovf_clr, led_wr, shadow_ld;
  assign rd_ram    = {1'b0, i_read_addr} < RAM_WORDS;
  assign wr_ram    = i_write_strobe && ({1'b0, i_write_addr} < RAM_WORDS);
  assign rd_io     = i_read_addr[15:3] == IO_BASE[15:3];
  assign wr_io     = i_write_strobe && (i_write_addr[15:3] == IO_BASE[15:3]);
  assign rd_off    = i_read_addr[2:0];
  assign wr_off    = i_write_addr[2:0];
  assign tx_empty  = tx_wp == tx_rp;
  assign tx_full   = (tx_wp ^ tx_rp) == FULL_XOR;
  assign rx_empty  = rx_wp == rx_rp;
  assign rx_full   = (rx_wp ^ rx_rp) == FULL_XOR;
  assign o_tx_valid = !tx_empty;
  assign o_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp[D-1:0]];
  assign tx_pop    = o_tx_valid && i_tx_ready;
  assign tx_push   = wr_io && wr_off == 3'd3 && (!tx_full || tx_pop);
  assign rx_pop    = rd_io && rd_off == 3'd4 && !rx_empty;
  assign rx_push   = i_rx_valid && (!rx_full || rx_pop);
  assign ovf_set   = i_rx_valid && rx_full && !rx_pop;
  assign ovf_clr   = wr_io && wr_off == 3'd5 && i_write_data[4];
  assign led_wr    = wr_io && wr_off == 3'd0;
  assign shadow_ld = rd_io && rd_off == 3'd1;
  assign ram_q     = (wr_ram && i_write_addr == i_read_addr) ? i_write_data : ram[i_read_addr[RAM_ADDR_WIDTH-1:0]];
  // read mux: RAM with write-first bypass, I/O page registers, zero for unmapped space
  always_comb begin
    rd_next = 16'h0000;
    if (rd_ram)
      rd_next = ram_q;
    else if (rd_io)
      case (rd_off)
        3'd0:    rd_next = {8'h00, led_wr ? i_write_data[7:0] : o_led};
        3'd1:    rd_next = timer[15:0];
        3'd2:    rd_next = timer_shadow;
        3'd4:    rd_next = rx_empty ? 16'h0000 : {7'b0, 1'b1, rx_mem[rx_rp[D-1:0]]};
        3'd5:    rd_next = {11'b0, rx_overflow, rx_full, rx_empty, tx_empty, tx_full};
        default: rd_next = 16'h0000;
      endcase
  end
  // RAM array has no reset so its contents survive a reset pulse
  always_ff @(posedge i_clk) begin
    if (wr_ram) ram[i_write_addr[RAM_ADDR_WIDTH-1:0]] <= i_write_data;
  end
  // FIFO storage; occupancy lives in the pointers so storage needs no reset
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wp[D-1:0]] <= i_write_data[7:0];
    if (rx_push) rx_mem[rx_wp[D-1:0]] <= i_rx_data;
  end
  // registered read data, LED, timer with high-half shadow, FIFO pointers and sticky overflow
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_read_data  <= '0;
      o_led        <= '0;
      timer        <= '0;
      timer_shadow <= '0;
      tx_wp        <= '0;
      tx_rp        <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_overflow  <= 1'b0;
    end else begin
      o_read_data  <= rd_next;
      o_led        <= led_wr ? i_write_data[7:0] : o_led;
      timer        <= timer + 32'd1;
      timer_shadow <= shadow_ld ? timer[31:16] : timer_shadow;
      tx_wp        <= tx_wp + (D+1)'(tx_push);
      tx_rp        <= tx_rp + (D+1)'(tx_pop);
      rx_wp        <= rx_wp + (D+1)'(rx_push);
      rx_rp        <= rx_rp + (D+1)'(rx_pop);
      rx_overflow  <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : rx_overflow;
    end
  end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: randomized and directed checks of memory_responder against a queue-based reference model
module tb_memory_responder;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_read_addr = '0, i_write_addr = '0, i_write_data = '0;
  logic        i_write_strobe = 1'b0, i_tx_ready = 1'b0, i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic [15:0] o_read_data;
  logic [7:0]  o_led, o_tx_data;
  logic        o_tx_valid;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] mram [int];
  logic [7:0]  led, txq[$], rxq[$], drained[$];
  logic        ovf;
  logic [15:0] shadow;
  logic [31:0] tcnt;

  memory_responder dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_read_addr(i_read_addr), .o_read_data(o_read_data),
    .i_write_addr(i_write_addr), .i_write_data(i_write_data), .i_write_strobe(i_write_strobe),
    .o_led(o_led), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    led = 8'h00;
    ovf = 1'b0;
    shadow = 16'h0000;
    tcnt = 32'd0;
  endtask

  task automatic step(input logic [15:0] ra, input logic [15:0] wa, input logic [15:0] wd,
                      input logic ws, input logic txr, input logic rxv, input logic [7:0] rxd);
    logic [15:0] exp;
    logic known;
    i_read_addr = ra; i_write_addr = wa; i_write_data = wd; i_write_strobe = ws;
    i_tx_ready = txr; i_rx_valid = rxv; i_rx_data = rxd;
    known = 1'b1;
    exp = 16'h0000;
    if (ra < 16'h1000) begin
      if (ws && wa == ra) exp = wd;
      else if (mram.exists(int'(ra))) exp = mram[int'(ra)];
      else known = 1'b0;
    end else if (ra >= 16'h8000 && ra <= 16'h8007) begin
      case (ra[2:0])
        3'd0:    exp = {8'h00, (ws && wa == 16'h8000) ? wd[7:0] : led};
        3'd1:    exp = tcnt[15:0];
        3'd2:    exp = shadow;
        3'd4:    exp = rxq.size() > 0 ? {8'h01, rxq[0]} : 16'h0000;
        3'd5:    exp = {11'b0, ovf, rxq.size() == 4, rxq.size() == 0, txq.size() == 0, txq.size() == 4};
        default: exp = 16'h0000;
      endcase
    end
    if (txq.size() > 0 && txr) drained.push_back(txq.pop_front());
    if (ws && wa == 16'h8003 && txq.size() < 4) txq.push_back(wd[7:0]);
    if (ra == 16'h8004 && rxq.size() > 0) void'(rxq.pop_front());
    if (ws && wa == 16'h8005 && wd[4]) ovf = 1'b0;
    if (rxv) begin
      if (rxq.size() < 4) rxq.push_back(rxd);
      else ovf = 1'b1;
    end
    if (ws && wa == 16'h8000) led = wd[7:0];
    if (ra == 16'h8001) shadow = tcnt[31:16];
    if (ws && wa < 16'h1000) mram[int'(wa)] = wd;
    tcnt++;
    @(posedge i_clk);
    #1;
    if (known) check("read_data", 32'(o_read_data), 32'(exp));
    check("tx_valid", 32'(o_tx_valid), 32'(txq.size() > 0));
    check("tx_data", 32'(o_tx_data), txq.size() > 0 ? 32'(txq[0]) : 32'd0);
    check("led", 32'(o_led), 32'(led));
  endtask

  task automatic rd(input logic [15:0] a);
    step(a, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(16'h4000, a, d, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    i_write_strobe = 1'b0; i_rx_valid = 1'b0; i_tx_ready = 1'b0; i_read_addr = 16'h4000;
    i_reset = 1'b1;
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    model_reset();
    @(posedge i_clk);
    tcnt++;
    #1;
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 16'($urandom_range(0, 15));
      2:       return 16'h8000 + 16'($urandom_range(0, 7));
      default: return $urandom_range(0, 1) ? 16'h4000 : 16'h9003;
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    check("rst_read_data", 32'(o_read_data), 32'h0);
    check("rst_led", 32'(o_led), 32'h0);
    check("rst_tx_valid", 32'(o_tx_valid), 32'h0);
    check("rst_tx_data", 32'(o_tx_data), 32'h0);
    @(negedge i_clk);
    rd(16'h8005);
    check("rst_status", 32'(o_read_data), 32'h0006);
    rd(16'h8002);
    check("rst_shadow", 32'(o_read_data), 32'h0000);
    wr(16'h0010, 16'h1234);
    rd(16'h0010);
    check("ram_rd", 32'(o_read_data), 32'h1234);
    step(16'h0011, 16'h0011, 16'hBEEF, 1'b1, 1'b0, 1'b0, 8'h00);
    check("ram_bypass", 32'(o_read_data), 32'hBEEF);
    wr(16'h0000, 16'h5555);
    wr(16'h8000, 16'h00A5);
    rd(16'h4000);
    check("unmapped_rd", 32'(o_read_data), 32'h0000);
    rd(16'h8006);
    check("reserved_rd", 32'(o_read_data), 32'h0000);
    wr(16'h4000, 16'hFFFF);
    rd(16'h0000);
    check("unmapped_wr_ram", 32'(o_read_data), 32'h5555);
    rd(16'h8000);
    check("unmapped_wr_led", 32'(o_read_data), 32'h00A5);

    do_reset();
    for (int i = 0; i < 5; i++) wr(16'h8003, 16'h0041 + 16'(i));
    rd(16'h8005);
    check("tx_status_full", 32'(o_read_data), 32'h0005);
    drained.delete();
    for (int i = 0; i < 5; i++) step(16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    check("tx_drain_cnt", 32'(drained.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("tx_drain_byte", 32'(drained[i]), 32'h41 + 32'(i));
    rd(16'h8005);
    check("tx_status_empty", 32'(o_read_data), 32'h0006);

    for (int i = 0; i < 5; i++) step(16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h10 + 8'(i));
    rd(16'h8005);
    check("rx_status_ovf", 32'(o_read_data), 32'h001A);
    for (int i = 0; i < 5; i++) begin
      rd(16'h8004);
      check("rx_pop", 32'(o_read_data), i < 4 ? 32'h0110 + 32'(i) : 32'h0);
    end
    wr(16'h8005, 16'h0010);
    rd(16'h8005);
    check("rx_ovf_clear", 32'(o_read_data), 32'h0006);

    for (int i = 0; i < 400; i++)
      step(rnd_addr(), rnd_addr(), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 8'($urandom));

    wr(16'h8000, 16'h005A);
    for (int i = 0; i < 3; i++) wr(16'h8003, 16'h0061 + 16'(i));
    rd(16'h0010);
    i_write_strobe = 1'b0; i_rx_valid = 1'b0; i_tx_ready = 1'b0;
    #3 i_reset = 1'b1;
    #1;
    check("async_led", 32'(o_led), 32'h0);
    check("async_tx_valid", 32'(o_tx_valid), 32'h0);
    check("async_read_data", 32'(o_read_data), 32'h0);
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    model_reset();
    @(negedge i_clk);
    rd(16'h0010);
    check("ram_retained", 32'(o_read_data), 32'h1234);

    do_reset();
    i_read_addr = 16'h4000;
    while (tcnt < 32'h0001_0005) begin
      @(posedge i_clk);
      tcnt++;
    end
    #1;
    rd(16'h8001);
    check("timer_lo", 32'(o_read_data), 32'h0005);
    rd(16'h8002);
    check("timer_hi", 32'(o_read_data), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
